pwm_capture_decoder: RTL and testbench

//  Receive-side counterpart to the deadtime PWM generator. Takes the complementary gate pair
//  (PWM_1/PWM_2) and, for every carrier period, measures high time, period and minimum deadtime.

---
 rtl/pwm_capture_decoder.sv | 194 +++++++++++++++++++
 tb/tb_pwm_capture_decoder.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture_decoder.sv
// pwm_capture_decoder
//   Receive-side decoder for a complementary, deadtime-separated gate pair.
//   For every carrier period (pwm_1 rise to pwm_1 rise) it reports the high
//   time, the period, the signed duty difference and the smallest both-low gap.
//   It also flags shoot-through (sticky) and a stalled carrier (watchdog).
//
//   State | Meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no period in progress; the next pwm_1 rise arms the measurement
//   HIGH  | pwm_1 high phase of the current period
//   LOW   | pwm_1 low phase; the next pwm_1 rise closes the period
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   pwm_1_in     high-side gate, asynchronous to clk
//   pwm_2_in     low-side gate, asynchronous to clk
//   meas_valid   one-cycle strobe; the measurement outputs update on this cycle
//   high_cnt     cycles pwm_1 was high in the last complete period
//   period_cnt   cycles from one pwm_1 rise to the next
//   duty_diff    signed 2*high_cnt - period_cnt
//   dt_min       smallest both-low gap preceding any rise in the period
//   dt_short     dt_min below MIN_DT
//   shoot_thru   sticky: both gates seen high together
//   timeout      carrier stalled; cleared by the next meas_valid
module pwm_capture_decoder #(
   parameter int CNT_W       = 16,
   parameter int DT_W        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_DT      = 5,
   parameter int TIMEOUT     = 65535
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    pwm_1_in,
   input  logic                    pwm_2_in,
   output logic                    meas_valid,
   output logic [CNT_W-1:0]        high_cnt,
   output logic [CNT_W-1:0]        period_cnt,
   output logic signed [CNT_W:0]   duty_diff,
   output logic [DT_W-1:0]         dt_min,
   output logic                    dt_short,
   output logic                    shoot_thru,
   output logic                    timeout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT);

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_1, sync_2;
   logic                   s1, s2, s1_d, s2_d;
   logic                   rise_1, rise_2;
   logic [CNT_W-1:0]       hi_ctr, per_ctr, wd_ctr;
   logic [DT_W-1:0]        gap_ctr, dt_run, dt_cand;
   logic                   dt_cand_short;
   logic                   wd_hit, stall, arm, latch;

   assign s1     = sync_1[SYNC_STAGES-1];
   assign s2     = sync_2[SYNC_STAGES-1];
   assign rise_1 = s1 & ~s1_d;
   assign rise_2 = s2 & ~s2_d;

   // gap_ctr still holds the both-low run ending in the previous cycle, so a
   // rise coinciding with the other side's fall naturally contributes 0.
   assign dt_cand       = ((rise_1 | rise_2) && (gap_ctr < dt_run)) ? gap_ctr : dt_run;
   assign dt_cand_short = int'(dt_cand) < MIN_DT;

   // A pwm_1 rise on the same cycle as the watchdog limit takes priority.
   assign wd_hit = (wd_ctr == WD_LIMIT);
   assign stall  = wd_hit & ~rise_1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      arm       = 1'b0;
      latch     = 1'b0;
      case (state)
         IDLE: begin
            if (rise_1) begin
               arm       = 1'b1;
               state_nxt = HIGH;
            end
         end
         HIGH: begin
            if (stall) begin
               state_nxt = IDLE;
            end else if (!s1) begin
               state_nxt = LOW;
            end
         end
         LOW: begin
            if (rise_1) begin
               latch     = 1'b1;
               state_nxt = HIGH;
            end else if (stall) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_1     <= '0;
         sync_2     <= '0;
         s1_d       <= 1'b0;
         s2_d       <= 1'b0;
         gap_ctr    <= '0;
         dt_run     <= '1;
         hi_ctr     <= '0;
         per_ctr    <= '0;
         wd_ctr     <= '0;
         meas_valid <= 1'b0;
         high_cnt   <= '0;
         period_cnt <= '0;
         duty_diff  <= '0;
         dt_min     <= '0;
         dt_short   <= 1'b0;
         shoot_thru <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         sync_1 <= {sync_1[SYNC_STAGES-2:0], pwm_1_in};
         sync_2 <= {sync_2[SYNC_STAGES-2:0], pwm_2_in};
         s1_d   <= s1;
         s2_d   <= s2;

         if (s1 | s2) begin
            gap_ctr <= '0;
         end else if (gap_ctr != '1) begin
            gap_ctr <= gap_ctr + 1'b1;
         end

         if (arm || latch || stall) begin
            dt_run <= '1;
         end else begin
            dt_run <= dt_cand;
         end

         // wd_ctr tracks per_ctr during a period and parks at the limit otherwise.
         if (rise_1) begin
            wd_ctr <= CNT_ONE;
         end else if (!wd_hit) begin
            wd_ctr <= wd_ctr + CNT_ONE;
         end

         if (arm || latch) begin
            hi_ctr  <= CNT_ONE;
            per_ctr <= CNT_ONE;
         end else if (stall) begin
            hi_ctr  <= '0;
            per_ctr <= '0;
         end else if (state == HIGH) begin
            per_ctr <= per_ctr + CNT_ONE;
            if (s1) begin
               hi_ctr <= hi_ctr + CNT_ONE;
            end
         end else if (state == LOW) begin
            per_ctr <= per_ctr + CNT_ONE;
         end

         meas_valid <= latch;
         if (latch) begin
            high_cnt   <= hi_ctr;
            period_cnt <= per_ctr;
            duty_diff  <= {hi_ctr, 1'b0} - {1'b0, per_ctr};
            dt_min     <= dt_cand;
            dt_short   <= dt_cand_short;
            timeout    <= 1'b0;
         end else if (stall) begin
            timeout <= 1'b1;
         end

         if (s1 & s2) begin
            shoot_thru <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture_decoder.sv
module tb_pwm_capture_decoder;

   localparam int CNT_W   = 16;
   localparam int DT_W    = 4;
   localparam int MIN_DT  = 5;
   localparam int TIMEOUT = 200;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  pwm_1_in, pwm_2_in;
   logic                  meas_valid;
   logic [CNT_W-1:0]      high_cnt, period_cnt;
   logic signed [CNT_W:0] duty_diff;
   logic [DT_W-1:0]       dt_min;
   logic                  dt_short, shoot_thru, timeout;

   pwm_capture_decoder #(
      .CNT_W(CNT_W), .DT_W(DT_W), .SYNC_STAGES(2), .MIN_DT(MIN_DT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .pwm_1_in(pwm_1_in), .pwm_2_in(pwm_2_in),
      .meas_valid(meas_valid), .high_cnt(high_cnt), .period_cnt(period_cnt),
      .duty_diff(duty_diff), .dt_min(dt_min), .dt_short(dt_short),
      .shoot_thru(shoot_thru), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] hi;
      logic [15:0] per;
      logic [16:0] dd;
      logic [3:0]  dt;
      logic        sh;
   } meas_t;

   meas_t exp_q[$];
   meas_t obs_q[$];
   meas_t prev;
   bit    have_prev;
   int    n_tests = 0;
   int    n_fail  = 0;

   always @(posedge clk) begin
      meas_t m;
      #1;
      if (meas_valid === 1'b1) begin
         m = {high_cnt, period_cnt, duty_diff, dt_min, dt_short};
         obs_q.push_back(m);
      end
   end

   function automatic meas_t model(input int hi, input int lo, input int ga, input int gb);
      meas_t m;
      int    g;
      g = (ga < gb) ? ga : gb;
      if (g > 15) g = 15;
      m.hi  = 16'(hi);
      m.per = 16'(hi + lo);
      m.dd  = 17'(2 * hi - (hi + lo));
      m.dt  = 4'(g);
      m.sh  = (g < MIN_DT);
      return m;
   endfunction

   task automatic cycle(input logic p1, input logic p2);
      pwm_1_in = p1;
      pwm_2_in = p2;
      @(negedge clk);
   endtask

   // One carrier period: pwm_2 rises ga cycles after pwm_1 falls and falls gb
   // cycles before the next pwm_1 rise. The rise that opens this period
   // closes the previous one, so that is when its expectation is queued.
   task automatic period(input int hi, input int lo, input int ga, input int gb,
                         input bit glitch);
      if (have_prev) exp_q.push_back(prev);
      for (int i = 0; i < hi; i++) cycle(1'b1, glitch && (i == hi / 2));
      for (int i = 0; i < lo; i++) cycle(1'b0, (i >= ga) && (i < lo - gb));
      prev = model(hi, lo, ga, gb);
      if (glitch) begin
         prev.dt = '0;
         prev.sh = 1'b1;
      end
      have_prev = 1'b1;
   endtask

   task automatic test_reset;
      logic [59:0] all_o;
      reset = 1'b1;
      pwm_1_in = 1'b0;
      pwm_2_in = 1'b0;
      repeat (3) @(negedge clk);
      all_o = {meas_valid, high_cnt, period_cnt, duty_diff, dt_min, dt_short, shoot_thru, timeout};
      n_tests++;
      if (all_o !== '0) begin
         n_fail++;
         $display("FAIL reset_hold: outputs=%h want 0", all_o);
      end
      reset = 1'b0;
      repeat (100) @(negedge clk);
      all_o = {meas_valid, high_cnt, period_cnt, duty_diff, dt_min, dt_short, shoot_thru, timeout};
      n_tests++;
      if (all_o !== '0) begin
         n_fail++;
         $display("FAIL reset_idle: outputs=%h want 0", all_o);
      end
      n_tests++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL reset_strobe: strobes=%0d want 0", obs_q.size());
      end
      obs_q.delete();
      exp_q.delete();
      have_prev = 1'b0;
   endtask

   task automatic test_nominal;
      meas_t e, o;
      int    hi, lo, ga, gb;
      for (int k = 0; k < 5; k++) period(30, 70, 5, 5, 1'b0);
      period(30, 70, 20, 20, 1'b0);
      for (int k = 0; k < 6; k++) begin
         hi = $urandom_range(60, 2);
         lo = $urandom_range(80, 12);
         ga = $urandom_range(18, 0);
         gb = $urandom_range(18, 0);
         if (ga + gb >= lo - 1) lo = ga + gb + 2;
         period(hi, lo, ga, gb, 1'b0);
      end
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL nominal_count: strobes=%0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL nominal: got hi=%0d per=%0d dd=%0d dt=%0d sh=%0d want hi=%0d per=%0d dd=%0d dt=%0d sh=%0d",
                     o.hi, o.per, $signed(o.dd), o.dt, o.sh, e.hi, e.per, $signed(e.dd), e.dt, e.sh);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_short_dt;
      meas_t e, o;
      for (int k = 0; k < 3; k++) period(30, 70, 2, 2, 1'b0);
      period(30, 70, 5, 0, 1'b0);
      period(30, 70, 5, 5, 1'b0);
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL short_dt_count: strobes=%0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL short_dt: got hi=%0d per=%0d dd=%0d dt=%0d sh=%0d want hi=%0d per=%0d dd=%0d dt=%0d sh=%0d",
                     o.hi, o.per, $signed(o.dd), o.dt, o.sh, e.hi, e.per, $signed(e.dd), e.dt, e.sh);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_shoot_thru;
      meas_t e, o;
      n_tests++;
      if (shoot_thru !== 1'b0) begin
         n_fail++;
         $display("FAIL shoot_thru_pre: shoot_thru=%b want 0", shoot_thru);
      end
      period(30, 70, 5, 5, 1'b1);
      for (int k = 0; k < 3; k++) period(30, 70, 5, 5, 1'b0);
      n_tests++;
      if (shoot_thru !== 1'b1) begin
         n_fail++;
         $display("FAIL shoot_thru_sticky: shoot_thru=%b want 1", shoot_thru);
      end
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL shoot_thru_count: strobes=%0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL shoot_thru: got hi=%0d per=%0d dd=%0d dt=%0d sh=%0d want hi=%0d per=%0d dd=%0d dt=%0d sh=%0d",
                     o.hi, o.per, $signed(o.dd), o.dt, o.sh, e.hi, e.per, $signed(e.dd), e.dt, e.sh);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_timeout;
      meas_t e, o;
      // A period of exactly TIMEOUT cycles: the closing rise beats the watchdog.
      period(30, TIMEOUT - 30, 5, 5, 1'b0);
      period(30, 70, 5, 5, 1'b0);
      n_tests++;
      if (timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_boundary: timeout=%b want 0", timeout);
      end
      exp_q.push_back(prev);
      have_prev = 1'b0;
      for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0);
      for (int i = 0; i < 165; i++) cycle(1'b0, 1'b0);
      n_tests++;
      if (timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_early: timeout=%b want 0 at 195 cycles", timeout);
      end
      for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0);
      n_tests++;
      if (timeout !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_set: timeout=%b want 1 at 210 cycles", timeout);
      end
      for (int i = 0; i < 70; i++) cycle(1'b0, 1'b0);
      n_tests++;
      if (high_cnt !== 16'd30 || period_cnt !== 16'd100) begin
         n_fail++;
         $display("FAIL timeout_hold: high_cnt=%0d period_cnt=%0d want 30 100", high_cnt, period_cnt);
      end
      period(30, 70, 5, 5, 1'b0);
      n_tests++;
      if (timeout !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_arm: timeout=%b want 1 after arming rise", timeout);
      end
      period(30, 70, 5, 5, 1'b0);
      n_tests++;
      if (timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_clear: timeout=%b want 0 after strobe", timeout);
      end
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL timeout_count: strobes=%0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL timeout_meas: got hi=%0d per=%0d dd=%0d dt=%0d sh=%0d want hi=%0d per=%0d dd=%0d dt=%0d sh=%0d",
                     o.hi, o.per, $signed(o.dd), o.dt, o.sh, e.hi, e.per, $signed(e.dd), e.dt, e.sh);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset_mid_high;
      meas_t       e, o;
      logic [59:0] all_o;
      // Put shoot_thru back up so the async clear below has something to clear.
      period(30, 70, 5, 5, 1'b1);
      exp_q.push_back(prev);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      all_o = {meas_valid, high_cnt, period_cnt, duty_diff, dt_min, dt_short, shoot_thru, timeout};
      n_tests++;
      if (all_o !== '0) begin
         n_fail++;
         $display("FAIL reset_async: outputs=%h want 0", all_o);
      end
      pwm_1_in = 1'b0;
      pwm_2_in = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      // Strobes before the reset belong to the pre-reset expectations.
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL reset_pre_count: strobes=%0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_pre: got hi=%0d per=%0d dd=%0d dt=%0d sh=%0d want hi=%0d per=%0d dd=%0d dt=%0d sh=%0d",
                     o.hi, o.per, $signed(o.dd), o.dt, o.sh, e.hi, e.per, $signed(e.dd), e.dt, e.sh);
         end
      end
      exp_q.delete();
      obs_q.delete();
      have_prev = 1'b0;
      for (int k = 0; k < 3; k++) period(40, 60, 6, 7, 1'b0);
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL reset_rearm_count: strobes=%0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_rearm: got hi=%0d per=%0d dd=%0d dt=%0d sh=%0d want hi=%0d per=%0d dd=%0d dt=%0d sh=%0d",
                     o.hi, o.per, $signed(o.dd), o.dt, o.sh, e.hi, e.per, $signed(e.dd), e.dt, e.sh);
         end
      end
      n_tests++;
      if (shoot_thru !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_shoot_thru: shoot_thru=%b want 0", shoot_thru);
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      reset     = 1'b1;
      pwm_1_in  = 1'b0;
      pwm_2_in  = 1'b0;
      have_prev = 1'b0;
      @(negedge clk);
      test_reset();
      test_nominal();
      test_short_dt();
      test_shoot_thru();
      test_timeout();
      test_reset_mid_high();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
